// File: rtl/fpu_add_sum_stage_pkg.sv
// Shared types and widths for the FPU adder fraction add/subtract stage.
package fpu_pkg;
    localparam int FRAC_W = 26;
    localparam int EXP_W  = 8;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } frm_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inv;
        logic dz;
    } flags_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              carry;
        logic              zero;
        frm_t              frm;
        flags_t            flags;
    } add_sum_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;
endpackage

// File: rtl/fpu_add_sum_stage_if.sv
// Operand/result handshake bundle between align stage, sum stage and normalise stage.
interface fpu_add_sum_stage_if;
    import fpu_pkg::*;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              sign1;
    logic              sign2;
    logic [EXP_W-1:0]  exponent_max;
    logic [FRAC_W-1:0] frac1;
    logic [FRAC_W-1:0] frac2;
    logic [2:0]        frm;
    logic              ovf_in;
    logic              unf_in;
    logic              inv;
    logic              dz;
    logic              out_valid;
    logic              out_ready;
    logic              sign_out;
    logic [EXP_W-1:0]  exponent_max_out;
    logic [FRAC_W-1:0] frac_out;
    logic              carry_out;
    logic              zero_result;
    logic [2:0]        frm_out;
    logic              ovf_out;
    logic              unf_out;
    logic              inv_out;
    logic              dz_out;

    modport master (
        output flush, in_valid, sign1, sign2, exponent_max, frac1, frac2, frm,
               ovf_in, unf_in, inv, dz, out_ready,
        input  in_ready, out_valid, sign_out, exponent_max_out, frac_out, carry_out,
               zero_result, frm_out, ovf_out, unf_out, inv_out, dz_out
    );

    modport slave (
        input  flush, in_valid, sign1, sign2, exponent_max, frac1, frac2, frm,
               ovf_in, unf_in, inv, dz, out_ready,
        output in_ready, out_valid, sign_out, exponent_max_out, frac_out, carry_out,
               zero_result, frm_out, ovf_out, unf_out, inv_out, dz_out
    );
endinterface

// File: rtl/fpu_add_sum_stage_frac_addsub.sv
// Combinational signed-magnitude fraction add/subtract; shared with the FMA path.
module frac_addsub
    import fpu_pkg::*;
(
    input  logic              sign1,
    input  logic              sign2,
    input  logic [EXP_W-1:0]  exp,
    input  logic [FRAC_W-1:0] frac1,
    input  logic [FRAC_W-1:0] frac2,
    input  logic [2:0]        frm,
    input  flags_t            flags,
    output add_sum_payload_t  res
);
    logic [FRAC_W:0] sum;

    always_comb begin
        res       = '0;
        sum       = '0;
        res.exp   = exp;
        res.frm   = frm_t'(frm);
        res.flags = flags;
        if (sign1 == sign2) begin
            // Same-signed zeros also land here and keep the operand sign.
            sum       = {1'b0, frac1} + {1'b0, frac2};
            res.carry = sum[FRAC_W];
            res.frac  = sum[FRAC_W-1:0];
            res.sign  = sign1;
            res.zero  = (sum == '0);
        end else if (frac1 == frac2) begin
            res.zero = 1'b1;
            res.sign = (frm_t'(frm) == RDN);
        end else if (frac1 > frac2) begin
            res.frac = frac1 - frac2;
            res.sign = sign1;
        end else begin
            res.frac = frac2 - frac1;
            res.sign = sign2;
        end
    end
endmodule

// File: rtl/fpu_add_sum_stage.sv
// Registered fraction add/sub stage (ADD_step2) with valid/ready on both sides.
// Optional 2-entry skid buffer with registered in_ready: define FPU_ADD_SKID_EN.
module fpu_add_sum_stage
    import fpu_pkg::*;
(
    input logic                 CLK,
    input logic                 rst,
    fpu_add_sum_stage_if.slave  bus
);
    add_sum_payload_t pl_new;
    add_sum_payload_t out_q;
    logic             out_valid_q;
    logic             acc;
    logic             cons;

    frac_addsub u_addsub (
        .sign1 (bus.sign1),
        .sign2 (bus.sign2),
        .exp   (bus.exponent_max),
        .frac1 (bus.frac1),
        .frac2 (bus.frac2),
        .frm   (bus.frm),
        .flags ('{ovf: bus.ovf_in, unf: bus.unf_in, inv: bus.inv, dz: bus.dz}),
        .res   (pl_new)
    );

    assign acc  = bus.in_valid & bus.in_ready;
    assign cons = out_valid_q & bus.out_ready;

`ifdef FPU_ADD_SKID_EN
    skid_state_t      state_q;
    add_sum_payload_t skid_q;
    logic             in_ready_q;

    assign bus.in_ready = in_ready_q;

    // TWO holds in_ready low, so no accept is possible from that state.
    always_ff @(posedge CLK) begin
        if (rst || bus.flush) begin
            state_q     <= EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (acc) begin
                    out_q       <= pl_new;
                    out_valid_q <= 1'b1;
                    state_q     <= ONE;
                end
                ONE: begin
                    if (acc && cons) begin
                        out_q <= pl_new;
                    end else if (acc) begin
                        skid_q     <= pl_new;
                        in_ready_q <= 1'b0;
                        state_q    <= TWO;
                    end else if (cons) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                TWO: if (cons) begin
                    out_q      <= skid_q;
                    in_ready_q <= 1'b1;
                    state_q    <= ONE;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end
`else
    assign bus.in_ready = ~out_valid_q | bus.out_ready;

    always_ff @(posedge CLK) begin
        if (rst || bus.flush) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (acc) begin
            out_q       <= pl_new;
            out_valid_q <= 1'b1;
        end else if (cons) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign bus.out_valid        = out_valid_q;
    assign bus.sign_out         = out_q.sign;
    assign bus.exponent_max_out = out_q.exp;
    assign bus.frac_out         = out_q.frac;
    assign bus.carry_out        = out_q.carry;
    assign bus.zero_result      = out_q.zero;
    assign bus.frm_out          = out_q.frm;
    assign bus.ovf_out          = out_q.flags.ovf;
    assign bus.unf_out          = out_q.flags.unf;
    assign bus.inv_out          = out_q.flags.inv;
    assign bus.dz_out           = out_q.flags.dz;
endmodule
